// File: rtl/histogram_engine.sv
// Pixel histogram engine: clears (optionally) then counts len pixels into an external bin RAM, 1 pixel/cycle.
// Define HISTOGRAM_SATURATE_EN for saturating counters plus a sticky overflow port.
module histogram_engine #(
   parameter int PIX_WIDTH      = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int COUNT_WIDTH    = 32,
   parameter int CLEAR_ON_START = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH:0]    len,
   output logic                   busy,
   output logic                   valid,
   output logic [ADDR_WIDTH-1:0]  arg_0_raddr_0,
   input  logic [PIX_WIDTH-1:0]   arg_0_rdata_0,
   output logic [PIX_WIDTH-1:0]   arg_1_raddr_0,
   input  logic [COUNT_WIDTH-1:0] arg_1_rdata_0,
   output logic [PIX_WIDTH-1:0]   arg_1_waddr_0,
   output logic [COUNT_WIDTH-1:0] arg_1_wdata_0,
   output logic                   arg_1_wen_0
`ifdef HISTOGRAM_SATURATE_EN
   ,
   output logic                   overflow
`endif
);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH:0]    ONE_L = 1;
   localparam logic [PIX_WIDTH-1:0]   ONE_P = 1;
   localparam logic [COUNT_WIDTH-1:0] ONE_C = 1;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH:0]    len_q, idx_q;
   logic [PIX_WIDTH-1:0]   clr_q, s2_bin_q, fwd_bin_q, raddr1_q, waddr_q;
   logic [COUNT_WIDTH-1:0] fwd_data_q, wdata_q, old_cnt, new_cnt;
   logic [ADDR_WIDTH-1:0]  raddr0_q;
   logic [2:1]             vld_pipe;
   logic                   fwd_v_q, s0_v, accept, fwd_hit;
`ifdef HISTOGRAM_SATURATE_EN
   logic                   clamp;
`endif

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign s0_v   = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      valid   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            valid = (state_q == DONE);
            if (start)
               state_d = (CLEAR_ON_START != 0) ? CLEAR : ((len == '0) ? DONE : RUN);
         end
         CLEAR: begin
            busy = 1'b1;
            if (&clr_q) state_d = (len_q == '0) ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (idx_q == len_q - ONE_L) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            // S2 retires its write at the end of this cycle, so only S1 must be empty
            if (!vld_pipe[1]) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The previous cycle's S2 write is not yet visible through the RAM read port
   assign fwd_hit = fwd_v_q && (fwd_bin_q == s2_bin_q);
   assign old_cnt = fwd_hit ? fwd_data_q : arg_1_rdata_0;
`ifdef HISTOGRAM_SATURATE_EN
   assign clamp   = &old_cnt;
   assign new_cnt = clamp ? old_cnt : old_cnt + ONE_C;
`else
   assign new_cnt = old_cnt + ONE_C;
`endif

   assign arg_0_raddr_0 = s0_v ? idx_q[ADDR_WIDTH-1:0] : raddr0_q;
   assign arg_1_raddr_0 = vld_pipe[1] ? arg_0_rdata_0 : raddr1_q;

   always_comb begin
      arg_1_waddr_0 = waddr_q;
      arg_1_wdata_0 = wdata_q;
      arg_1_wen_0   = 1'b0;
      if (state_q == CLEAR) begin
         arg_1_waddr_0 = clr_q;
         arg_1_wdata_0 = '0;
         arg_1_wen_0   = 1'b1;
      end else if (vld_pipe[2]) begin
         arg_1_waddr_0 = s2_bin_q;
         arg_1_wdata_0 = new_cnt;
         arg_1_wen_0   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         clr_q      <= '0;
         vld_pipe   <= '0;
         s2_bin_q   <= '0;
         fwd_v_q    <= 1'b0;
         fwd_bin_q  <= '0;
         fwd_data_q <= '0;
         raddr0_q   <= '0;
         raddr1_q   <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
`ifdef HISTOGRAM_SATURATE_EN
         overflow   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         vld_pipe <= {vld_pipe[1], s0_v};
         raddr0_q <= arg_0_raddr_0;
         raddr1_q <= arg_1_raddr_0;
         waddr_q  <= arg_1_waddr_0;
         wdata_q  <= arg_1_wdata_0;
         if (vld_pipe[1]) s2_bin_q <= arg_0_rdata_0;
         fwd_v_q <= vld_pipe[2];
         if (vld_pipe[2]) begin
            fwd_bin_q  <= s2_bin_q;
            fwd_data_q <= new_cnt;
         end
         if (accept) begin
            len_q <= len;
            idx_q <= '0;
            clr_q <= '0;
         end else begin
            if (state_q == CLEAR) clr_q <= clr_q + ONE_P;
            if (s0_v) idx_q <= idx_q + ONE_L;
         end
`ifdef HISTOGRAM_SATURATE_EN
         if (accept) overflow <= 1'b0;
         else if (vld_pipe[2] && clamp) overflow <= 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: two instances (clear-on-start and accumulate) with behavioural RAMs and a histogram model.
module tb_histogram_engine;
   localparam int PW = 8;
   localparam int AW = 12;
   localparam int CW = 32;
   localparam int NB = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic          a_start, a_busy, a_valid, a_wen;
   logic [AW:0]   a_len;
   logic [AW-1:0] a_raddr0;
   logic [PW-1:0] a_rdata0, a_raddr1, a_waddr;
   logic [CW-1:0] a_rdata1, a_wdata;
   logic          b_start, b_busy, b_valid, b_wen;
   logic [AW:0]   b_len;
   logic [AW-1:0] b_raddr0;
   logic [PW-1:0] b_rdata0, b_raddr1, b_waddr;
   logic [CW-1:0] b_rdata1, b_wdata;
`ifdef HISTOGRAM_SATURATE_EN
   logic          a_ovf, b_ovf;
   bit            ovf_exp [2];
`endif

   histogram_engine #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .CLEAR_ON_START(1)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .len(a_len), .busy(a_busy), .valid(a_valid),
      .arg_0_raddr_0(a_raddr0), .arg_0_rdata_0(a_rdata0), .arg_1_raddr_0(a_raddr1),
      .arg_1_rdata_0(a_rdata1), .arg_1_waddr_0(a_waddr), .arg_1_wdata_0(a_wdata),
      .arg_1_wen_0(a_wen)
`ifdef HISTOGRAM_SATURATE_EN
      , .overflow(a_ovf)
`endif
   );

   histogram_engine #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .CLEAR_ON_START(0)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .len(b_len), .busy(b_busy), .valid(b_valid),
      .arg_0_raddr_0(b_raddr0), .arg_0_rdata_0(b_rdata0), .arg_1_raddr_0(b_raddr1),
      .arg_1_rdata_0(b_rdata1), .arg_1_waddr_0(b_waddr), .arg_1_wdata_0(b_wdata),
      .arg_1_wen_0(b_wen)
`ifdef HISTOGRAM_SATURATE_EN
      , .overflow(b_ovf)
`endif
   );

   // External RAMs: 1-cycle read latency, read-before-write, plus a bench preload port
   logic [PW-1:0] a_pix [1<<AW];
   logic [PW-1:0] b_pix [1<<AW];
   logic [CW-1:0] a_bin [NB];
   logic [CW-1:0] b_bin [NB];
   logic          pl_a = 1'b0, pl_b = 1'b0;
   logic [PW-1:0] pl_addr = '0;
   logic [CW-1:0] pl_data = '0;

   always @(posedge clk) begin
      a_rdata0 <= a_pix[a_raddr0];
      a_rdata1 <= a_bin[a_raddr1];
      if (a_wen) a_bin[a_waddr] <= a_wdata;
      else if (pl_a) a_bin[pl_addr] <= pl_data;
      b_rdata0 <= b_pix[b_raddr0];
      b_rdata1 <= b_bin[b_raddr1];
      if (b_wen) b_bin[b_waddr] <= b_wdata;
      else if (pl_b) b_bin[pl_addr] <= pl_data;
   end

   // Model: per instance, start cycle, done cycle, and the expected write sequence
   bit            clr [2] = '{1'b1, 1'b0};
   int            s_cyc [2] = '{-1, -1};
   int            done_cyc [2];
   int            wbase [2];
   int            wn [2];
   logic [PW-1:0] wq_addr [2][4096];
   logic [CW-1:0] wq_data [2][4096];
   logic [CW-1:0] exp_hist [2][NB];
   logic [PW-1:0] px [$];
   bit            chk_en = 1'b0;

   logic [1:0]    busy_v, valid_v, wen_v;
   logic [PW-1:0] waddr_v [2];
   logic [CW-1:0] wdata_v [2];
   assign busy_v  = {b_busy, a_busy};
   assign valid_v = {b_valid, a_valid};
   assign wen_v   = {b_wen, a_wen};
   assign waddr_v[0] = a_waddr;
   assign waddr_v[1] = b_waddr;
   assign wdata_v[0] = a_wdata;
   assign wdata_v[1] = b_wdata;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] binrd(input int d, input int i);
      return (d == 0) ? a_bin[i] : b_bin[i];
   endfunction

   // Cycle-by-cycle handshake and write-port check against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            bit eb, ev, ew;
            logic [PW-1:0] ea;
            logic [CW-1:0] ed;
            eb = 1'b0; ev = 1'b0; ew = 1'b0; ea = '0; ed = '0;
            if (s_cyc[d] >= 0) begin
               eb = (cyc > s_cyc[d]) && (cyc < done_cyc[d]);
               ev = (cyc >= done_cyc[d]);
               if (clr[d] && cyc > s_cyc[d] && cyc <= s_cyc[d] + NB) begin
                  ew = 1'b1;
                  ea = PW'(cyc - s_cyc[d] - 1);
               end else if (cyc >= wbase[d] && cyc < wbase[d] + wn[d]) begin
                  ew = 1'b1;
                  ea = wq_addr[d][cyc - wbase[d]];
                  ed = wq_data[d][cyc - wbase[d]];
               end
            end
            chk($sformatf("busy%0d", d), 64'(busy_v[d]), 64'(eb));
            chk($sformatf("valid%0d", d), 64'(valid_v[d]), 64'(ev));
            chk($sformatf("wen%0d", d), 64'(wen_v[d]), 64'(ew));
            if (ew) begin
               chk($sformatf("waddr%0d", d), 64'(waddr_v[d]), 64'(ea));
               chk($sformatf("wdata%0d", d), 64'(wdata_v[d]), 64'(ed));
            end
         end
      end
   end

   task automatic launch(input int d, input int n);
      logic [CW-1:0] cur;
      for (int k = 0; k < n; k++) begin
         if (d == 0) a_pix[k] = px[k];
         else b_pix[k] = px[k];
      end
      if (clr[d]) for (int i = 0; i < NB; i++) exp_hist[d][i] = '0;
`ifdef HISTOGRAM_SATURATE_EN
      ovf_exp[d] = 1'b0;
`endif
      for (int k = 0; k < n; k++) begin
         cur = exp_hist[d][px[k]];
`ifdef HISTOGRAM_SATURATE_EN
         if (cur == {CW{1'b1}}) ovf_exp[d] = 1'b1;
         else cur = cur + 1;
`else
         cur = cur + 1;
`endif
         exp_hist[d][px[k]] = cur;
         wq_addr[d][k] = px[k];
         wq_data[d][k] = cur;
      end
      @(negedge clk); #1;
      s_cyc[d]    = cyc;
      done_cyc[d] = cyc + (clr[d] ? NB : 0) + ((n == 0) ? 1 : n + 3);
      wbase[d]    = cyc + (clr[d] ? NB : 0) + 3;
      wn[d]       = n;
      if (d == 0) begin a_len = (AW+1)'(n); a_start = 1'b1; end
      else begin b_len = (AW+1)'(n); b_start = 1'b1; end
      @(negedge clk); #1;
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic finish_run(input int d, input int exp_lat);
      int i;
      i = 0;
      while (!valid_v[d] && i < 5000) begin
         @(negedge clk); #1;
         i++;
      end
      if (!valid_v[d]) chk($sformatf("valid_timeout%0d", d), 64'(i), 64'(0));
      else chk($sformatf("latency%0d", d), 64'(cyc - s_cyc[d]), 64'(exp_lat));
      @(negedge clk); #1;
      for (int b = 0; b < NB; b++) chk($sformatf("bin%0d[%0d]", d, b), 64'(binrd(d, b)), 64'(exp_hist[d][b]));
`ifdef HISTOGRAM_SATURATE_EN
      chk($sformatf("overflow%0d", d), 64'((d == 0) ? a_ovf : b_ovf), 64'(ovf_exp[d]));
`endif
   endtask

   initial begin
      a_start = 1'b0; b_start = 1'b0; a_len = '0; b_len = '0;
      for (int k = 0; k < (1<<AW); k++) begin a_pix[k] = '0; b_pix[k] = '0; end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy", 64'({a_busy, b_busy}), 64'(0));
      chk("rst_valid", 64'({a_valid, b_valid}), 64'(0));
      chk("rst_wen", 64'({a_wen, b_wen}), 64'(0));
      chk("rst_raddr", 64'({a_raddr0, a_raddr1, a_waddr}), 64'(0));
`ifdef HISTOGRAM_SATURATE_EN
      chk("rst_ovf", 64'({a_ovf, b_ovf}), 64'(0));
`endif
      chk_en = 1'b1;
      // Junk in every bin, so the clear phase is visible
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         pl_a = 1'b1; pl_b = 1'b1; pl_addr = PW'(i); pl_data = 32'hDEAD0000 | i;
         exp_hist[0][i] = 32'hDEAD0000 | i;
         exp_hist[1][i] = 32'hDEAD0000 | i;
      end
      @(negedge clk);
      pl_a = 1'b0; pl_b = 1'b0;

      px = '{8'd3, 8'd7, 8'd3, 8'd9};
      launch(0, 4); finish_run(0, 263);
      chk("pin_bin3", 64'(a_bin[3]), 64'(2));
      chk("pin_bin7", 64'(a_bin[7]), 64'(1));
      chk("pin_bin9", 64'(a_bin[9]), 64'(1));

      px = '{8'd42, 8'd42, 8'd42, 8'd42, 8'd42};
      launch(0, 5); finish_run(0, 264);
      chk("pin_bin42", 64'(a_bin[42]), 64'(5));

      px = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1};
      launch(0, 5); finish_run(0, 264);
      chk("pin_bin1", 64'(a_bin[1]), 64'(3));
      chk("pin_bin2", 64'(a_bin[2]), 64'(2));

      px = {};
      launch(0, 0); finish_run(0, 257);
      chk("pin_len0_bin1", 64'(a_bin[1]), 64'(0));

      b_pix[0] = 8'd77;
      launch(1, 0); finish_run(1, 1);
      chk("pin_b_len0_bin77", 64'(b_bin[77]), 64'(32'hDEAD004D));

      @(negedge clk);
      pl_b = 1'b1; pl_addr = 8'd5; pl_data = 32'hFFFFFFFF;
      exp_hist[1][5] = 32'hFFFFFFFF;
      @(negedge clk);
      pl_b = 1'b0;
      px = '{8'd5};
      launch(1, 1); finish_run(1, 4);
`ifdef HISTOGRAM_SATURATE_EN
      chk("pin_sat_bin5", 64'(b_bin[5]), 64'(32'hFFFFFFFF));
      chk("pin_sat_ovf", 64'(b_ovf), 64'(1));
`else
      chk("pin_wrap_bin5", 64'(b_bin[5]), 64'(0));
`endif

      // Reset during RUN cycle 3 (third RUN cycle after the clear)
      px = '{8'd3, 8'd7, 8'd3, 8'd9};
      launch(0, 4);
      repeat (258) @(negedge clk);
      #1;
      chk_en = 1'b0;
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      s_cyc[0] = -1; s_cyc[1] = -1;
      chk("mid_rst_busy", 64'({a_busy, b_busy}), 64'(0));
      chk("mid_rst_valid", 64'({a_valid, b_valid}), 64'(0));
      chk("mid_rst_wen", 64'({a_wen, b_wen}), 64'(0));
      chk("mid_rst_addr", 64'({a_raddr0, a_raddr1, a_waddr}), 64'(0));
      chk("mid_rst_wdata", 64'(a_wdata), 64'(0));
      chk_en = 1'b1;

      px = '{8'd0, 8'd0};
      launch(0, 2); finish_run(0, 261);
      chk("pin_restart_bin0", 64'(a_bin[0]), 64'(2));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
